// File: rtl/ama_riscv_defines.sv
// Shared load/store encodings: access widths and RV32I load funct3 values.
// Used by the store byte-mask logic and the load alignment path alike.
package ama_riscv_defines;

   localparam int XLEN  = 32;
   localparam int LANES = 4;

   // funct3[1:0] width field
   localparam logic [1:0] BYTE = 2'd0;
   localparam logic [1:0] HALF = 2'd1;
   localparam logic [1:0] WORD = 2'd2;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

   typedef struct packed {
      logic       vld;
      logic [1:0] offset;
      logic [2:0] funct3;
   } ld_stage_t;

   // Access fits in the word only if it does not run past lane 3; LWU is RV64-only.
   function automatic logic ld_illegal(input logic [1:0] offset, input logic [2:0] funct3);
      logic bad;
      bad = 1'b0;
      case (funct3[1:0])
         BYTE:    bad = 1'b0;
         HALF:    bad = (offset == 2'd3);
         WORD:    bad = (offset != 2'd0) || funct3[2];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ama_riscv_load_extend.sv
// Combinational shift and sign/zero extension of a DMEM read word into a
// register-file value, with the same legality table as the store mask.
module ama_riscv_load_extend
   import ama_riscv_defines::*;
(
   input  logic [XLEN-1:0] src,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data,
   output logic            err
);

   logic [XLEN-1:0] shifted;
   logic            uns;

   assign shifted = src >> {offset, 3'b000};
   assign uns     = funct3[2];

   function automatic logic [XLEN-1:0] ext_byte(input logic [7:0] b, input logic u);
      return u ? {24'h0, b} : {{24{b[7]}}, b};
   endfunction

   function automatic logic [XLEN-1:0] ext_half(input logic [15:0] h, input logic u);
      return u ? {16'h0, h} : {{16{h[15]}}, h};
   endfunction

   always_comb begin
      data = '0;
      err  = ld_illegal(offset, funct3);
      if (!err) begin
         case (funct3[1:0])
            BYTE:    data = ext_byte(shifted[7:0], uns);
            HALF:    data = ext_half(shifted[15:0], uns);
            WORD:    data = src;
            default: data = '0;
         endcase
      end
   end

endmodule

// File: rtl/ama_riscv_load_align.sv
// MEM-stage load alignment: captures the load in EX, holds the DMEM word
// across stalls, and produces the aligned/extended writeback value.
module ama_riscv_load_align
   import ama_riscv_defines::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_en,
   input  logic [1:0]      req_offset,
   input  logic [2:0]      req_funct3,
   input  logic            stall,
   input  logic            flush,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            dmem_rd_en,
   output logic            load_valid,
   output logic [XLEN-1:0] load_data,
   output logic            load_err
);

   ld_stage_t       stage_d, stage_q;
   logic            hold_vld_d, hold_vld_q;
   logic [XLEN-1:0] hold_data_d, hold_data_q;
   logic [XLEN-1:0] src;
   logic [XLEN-1:0] ext_data;
   logic            ext_err;

   assign dmem_rd_en = req_en & ~stall;

   always_comb begin
      stage_d = stage_q;
      if (flush) begin
         stage_d.vld = 1'b0;
      end else if (!stall) begin
         stage_d.vld    = req_en;
         stage_d.offset = req_offset;
         stage_d.funct3 = req_funct3;
      end
   end

   // The DMEM output moves once the address changes, so freeze the word
   // seen in the first stalled cycle and serve it until MEM advances.
   always_comb begin
      hold_vld_d  = hold_vld_q;
      hold_data_d = hold_data_q;
      if (flush || !stall) begin
         hold_vld_d = 1'b0;
      end else if (stage_q.vld && !hold_vld_q) begin
         hold_vld_d  = 1'b1;
         hold_data_d = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q     <= '0;
         hold_vld_q  <= 1'b0;
         hold_data_q <= '0;
      end else begin
         stage_q     <= stage_d;
         hold_vld_q  <= hold_vld_d;
         hold_data_q <= hold_data_d;
      end
   end

   assign src = hold_vld_q ? hold_data_q : mem_rdata;

   ama_riscv_load_extend u_extend (
      .src    (src),
      .offset (stage_q.offset),
      .funct3 (stage_q.funct3),
      .data   (ext_data),
      .err    (ext_err)
   );

   assign load_valid = stage_q.vld;
   assign load_data  = stage_q.vld ? ext_data : '0;
   assign load_err   = stage_q.vld & ext_err;

endmodule

// File: tb/tb_ama_riscv_load_align.sv
// Bench for ama_riscv_load_align: directed vector table, stall/flush/reset
// sequences and a randomized run against a behavioural load model.
module tb_ama_riscv_load_align;

   logic        clk;
   logic        rst_n;
   logic        req_en;
   logic [1:0]  req_offset;
   logic [2:0]  req_funct3;
   logic        stall;
   logic        flush;
   logic [31:0] mem_rdata;
   logic        dmem_rd_en;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_err;

   int checks;
   int failures;

   ama_riscv_load_align dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_en     (req_en),
      .req_offset (req_offset),
      .req_funct3 (req_funct3),
      .stall      (stall),
      .flush      (flush),
      .mem_rdata  (mem_rdata),
      .dmem_rd_en (dmem_rd_en),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_err   (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] rdata;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: select the addressed bytes arithmetically and extend them.
   function automatic void ref_load(input logic [31:0] w, input int off, input logic [2:0] f3,
                                    output logic [31:0] d, output logic e);
      int     nbytes;
      longint v;
      longint lane_div;
      longint field_mod;
      nbytes = 1 << f3[1:0];
      e = (f3[1:0] == 2'd3) || (f3 == 3'b110) || (off + nbytes > 4);
      d = '0;
      if (!e) begin
         lane_div  = longint'(1) << (8 * off);
         field_mod = longint'(1) << (8 * nbytes);
         v = (longint'({32'h0, w}) / lane_div) % field_mod;
         if (!f3[2] && v >= field_mod / 2) v = v - field_mod;
         d = v[31:0];
      end
   endfunction

   vec_t vecs[$];

   initial begin
      logic        m_vld, m_have;
      logic [1:0]  m_off;
      logic [2:0]  m_f3;
      logic [31:0] m_word, e_d;
      logic        e_e;
      logic [31:0] a_w, b_w, c_w;

      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      req_en = 1'b1;
      req_offset = 2'd0;
      req_funct3 = 3'b010;
      stall = 1'b0;
      flush = 1'b0;
      mem_rdata = 32'hA5A5_5A5A;

      // Reset state
      #2;
      chk("rst_valid", {31'h0, load_valid}, 32'h0);
      chk("rst_data", load_data, 32'h0);
      chk("rst_err", {31'h0, load_err}, 32'h0);
      chk("rst_rd_en", {31'h0, dmem_rd_en}, 32'h1);
      stall = 1'b1;
      #1;
      chk("rst_rd_en_stall", {31'h0, dmem_rd_en}, 32'h0);
      stall = 1'b0;
      req_en = 1'b0;
      #9;
      rst_n = 1'b1;
      tick();
      chk("idle_valid", {31'h0, load_valid}, 32'h0);

      // Directed vector table
      vecs.push_back('{3'b000, 2'd3, 32'h8012_3456, 32'hFFFF_FF80, 1'b0});
      vecs.push_back('{3'b100, 2'd3, 32'h8012_3456, 32'h0000_0080, 1'b0});
      vecs.push_back('{3'b001, 2'd1, 32'h009A_BC00, 32'hFFFF_9ABC, 1'b0});
      vecs.push_back('{3'b101, 2'd1, 32'h009A_BC00, 32'h0000_9ABC, 1'b0});
      vecs.push_back('{3'b001, 2'd3, 32'h009A_BC00, 32'h0000_0000, 1'b1});
      vecs.push_back('{3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{3'b010, 2'd1, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
      vecs.push_back('{3'b010, 2'd2, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
      vecs.push_back('{3'b010, 2'd3, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
      vecs.push_back('{3'b110, 2'd0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
      vecs.push_back('{3'b011, 2'd0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
      vecs.push_back('{3'b111, 2'd0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1});
      vecs.push_back('{3'b100, 2'd0, 32'h1234_5678, 32'h0000_0078, 1'b0});
      vecs.push_back('{3'b000, 2'd1, 32'h1234_5678, 32'h0000_0056, 1'b0});
      vecs.push_back('{3'b000, 2'd2, 32'h12F4_5678, 32'hFFFF_FFF4, 1'b0});
      vecs.push_back('{3'b001, 2'd2, 32'h8000_1234, 32'hFFFF_8000, 1'b0});
      vecs.push_back('{3'b001, 2'd0, 32'h1234_7FFF, 32'h0000_7FFF, 1'b0});
      vecs.push_back('{3'b101, 2'd0, 32'h1234_FFFF, 32'h0000_FFFF, 1'b0});

      foreach (vecs[i]) begin
         req_en = 1'b1;
         req_funct3 = vecs[i].f3;
         req_offset = vecs[i].off;
         mem_rdata = 32'h0;
         tick();
         req_en = 1'b0;
         mem_rdata = vecs[i].rdata;
         #2;
         chk($sformatf("vec%0d_valid", i), {31'h0, load_valid}, 32'h1);
         chk($sformatf("vec%0d_data", i), load_data, vecs[i].exp_data);
         chk($sformatf("vec%0d_err", i), {31'h0, load_err}, {31'h0, vecs[i].exp_err});
         tick();
      end

      // Back-to-back LB / LH / LW
      a_w = 32'h0000_00C3;
      b_w = 32'h7654_0000;
      c_w = 32'hCAFE_F00D;
      req_en = 1'b1; req_funct3 = 3'b000; req_offset = 2'd0;
      tick();
      req_funct3 = 3'b001; req_offset = 2'd2; mem_rdata = a_w;
      #2;
      chk("b2b_lb", load_data, 32'hFFFF_FFC3);
      tick();
      req_funct3 = 3'b010; req_offset = 2'd0; mem_rdata = b_w;
      #2;
      chk("b2b_lh", load_data, 32'h0000_7654);
      tick();
      req_en = 1'b0; mem_rdata = c_w;
      #2;
      chk("b2b_lw", load_data, 32'hCAFE_F00D);
      chk("b2b_lw_valid", {31'h0, load_valid}, 32'h1);
      tick();

      // Stall of 3 cycles with changing mem_rdata
      req_en = 1'b1; req_funct3 = 3'b010; req_offset = 2'd0;
      tick();
      stall = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      #2;
      chk("stall0_data", load_data, 32'hDEAD_BEEF);
      chk("stall0_rd_en", {31'h0, dmem_rd_en}, 32'h0);
      tick();
      mem_rdata = 32'h1111_1111;
      for (int k = 1; k < 3; k++) begin
         #2;
         chk($sformatf("stall%0d_data", k), load_data, 32'hDEAD_BEEF);
         chk($sformatf("stall%0d_rd_en", k), {31'h0, dmem_rd_en}, 32'h0);
         tick();
      end
      stall = 1'b0; req_en = 1'b0;
      #2;
      chk("stall_rel_data", load_data, 32'hDEAD_BEEF);
      tick();
      #2;
      chk("stall_after_valid", {31'h0, load_valid}, 32'h0);
      tick();

      // flush with concurrent stall
      req_en = 1'b1; req_funct3 = 3'b010; req_offset = 2'd0;
      tick();
      req_en = 1'b0; stall = 1'b1; flush = 1'b1;
      tick();
      stall = 1'b0; flush = 1'b0;
      #2;
      chk("flush_stall_valid", {31'h0, load_valid}, 32'h0);
      tick();

      // flush with concurrent req_en
      req_en = 1'b1; flush = 1'b1;
      tick();
      req_en = 1'b0; flush = 1'b0;
      #2;
      chk("flush_req_valid", {31'h0, load_valid}, 32'h0);
      tick();

      // Reset during a held stall
      req_en = 1'b1; req_funct3 = 3'b010; req_offset = 2'd0;
      tick();
      req_en = 1'b0; stall = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_rdata = 32'h5555_AAAA;
      #1;
      chk("pre_rst_held", load_data, 32'hDEAD_BEEF);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'h0, load_valid}, 32'h0);
      chk("mid_rst_data", load_data, 32'h0);
      chk("mid_rst_err", {31'h0, load_err}, 32'h0);
      stall = 1'b0;
      #4;
      rst_n = 1'b1;
      tick();
      req_en = 1'b1; req_funct3 = 3'b010; req_offset = 2'd0;
      tick();
      req_en = 1'b0; mem_rdata = 32'h1234_5678;
      #2;
      chk("post_rst_fresh", load_data, 32'h1234_5678);
      tick();
      tick();

      // Randomized run against the behavioural model
      m_vld = 1'b0; m_have = 1'b0; m_off = '0; m_f3 = '0; m_word = '0;
      for (int c = 0; c < 400; c++) begin
         req_en     = ($urandom_range(0, 3) != 0);
         req_offset = 2'($urandom_range(0, 3));
         req_funct3 = 3'($urandom_range(0, 7));
         stall      = ($urandom_range(0, 3) == 0);
         flush      = ($urandom_range(0, 9) == 0);
         mem_rdata  = $urandom;
         if (m_vld && !m_have) begin
            m_word = mem_rdata;
            m_have = 1'b1;
         end
         #2;
         if (m_vld) ref_load(m_word, int'(m_off), m_f3, e_d, e_e);
         else begin
            e_d = '0;
            e_e = 1'b0;
         end
         chk("rnd_valid", {31'h0, load_valid}, {31'h0, m_vld});
         chk("rnd_data", load_data, e_d);
         chk("rnd_err", {31'h0, load_err}, {31'h0, e_e});
         chk("rnd_rd_en", {31'h0, dmem_rd_en}, {31'h0, req_en & ~stall});
         if (flush) begin
            m_vld = 1'b0;
            m_have = 1'b0;
         end else if (!stall) begin
            m_vld = req_en;
            m_off = req_offset;
            m_f3 = req_funct3;
            m_have = 1'b0;
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
